// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a miss FSM
// that writes back a dirty victim and fills a 256-bit line from slow memory.
module dcache_controller #(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W   = $clog2(LINE_BITS / 32);

    typedef enum logic [1:0] {
        IDLE,
        WB_REQ,
        FILL_REQ,
        FILL_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]     tag_arr  [LINES];
    logic [LINE_BITS-1:0] data_arr [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [ADDR_W-1:0]    addr_q;

    logic [ADDR_W-1:0]    eff_addr;
    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [LINE_BITS-1:0] sel_line;
    logic [31:0]          sel_word;
    logic                 req;
    logic                 is_load;
    logic                 hit;
    logic                 store_hit;
    logic                 unused_byte;

    // Live address only while idle; the captured copy drives the whole miss.
    assign eff_addr    = (state_q == IDLE) ? cpu_addr_i : addr_q;
    assign idx         = eff_addr[OFFSET_W +: INDEX_W];
    assign tag         = eff_addr[ADDR_W-1 -: TAG_W];
    assign wsel        = eff_addr[2 +: WSEL_W];
    assign unused_byte = ^eff_addr[1:0];

    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_load   = cpu_MemRead_i & ~cpu_MemWrite_i;
    assign hit       = valid_q[idx] & (tag_arr[idx] == tag);
    assign sel_line  = data_arr[idx];
    assign sel_word  = sel_line[{wsel, 5'b0} +: 32];
    assign store_hit = cpu_MemWrite_i & hit &
                       ((state_q == IDLE) | (state_q == FILL_DONE));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req && !hit)
                addr_q <= cpu_addr_i;
            if (state_q == FILL_REQ && mem_ack_i) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (store_hit)
                dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == FILL_REQ && mem_ack_i) begin
            data_arr[idx] <= mem_data_i;
            tag_arr[idx]  <= tag;
        end
        if (store_hit)
            data_arr[idx][{wsel, 5'b0} +: 32] <= cpu_data_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : FILL_REQ;
            end
            WB_REQ:    if (mem_ack_i) state_d = FILL_REQ;
            FILL_REQ:  if (mem_ack_i) state_d = FILL_DONE;
            FILL_DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_data_o   = '0;
        cpu_stall_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_stall_o = req & ~hit;
                if (is_load && hit)
                    cpu_data_o = sel_word;
            end
            WB_REQ: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_arr[idx], idx, {OFFSET_W{1'b0}}};
                mem_data_o   = sel_line;
            end
            FILL_REQ: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
            end
            FILL_DONE: begin
                if (is_load)
                    cpu_data_o = sel_word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: miss/fill/write-back sequences with a
// cycle-stepped memory responder, plus a table of hit vectors.
module tb_dcache_controller;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;

    int           nph;
    logic         ph_wr   [2];
    logic [31:0]  ph_addr [2];
    logic [255:0] ph_data [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    dcache_controller #(.LINES(16), .LINE_BITS(256), .ADDR_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] first);
        logic [255:0] l;
        for (int unsigned i = 0; i < 8; i++)
            l[i*32 +: 32] = first + i;
        return l;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = a;
        cpu_data_i     = d;
    endtask

    // Steps cycle by cycle from the request cycle until stall drops, logging
    // every memory phase and acking each one after 'lat' wait cycles.
    task automatic run_miss(input int lat, input logic [255:0] fill, output int stalls);
        int cnt;
        bit done;
        stalls     = 0;
        nph        = 0;
        cnt        = 0;
        done       = 0;
        mem_data_i = fill;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_enable_o) begin
                    if (cnt == 0) begin
                        if (nph < 2) begin
                            ph_wr[nph]   = mem_write_o;
                            ph_addr[nph] = mem_addr_o;
                            ph_data[nph] = mem_data_o;
                        end
                        nph++;
                    end
                    if (cnt == lat) begin
                        mem_ack_i = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
                @(posedge clk_i);
                #1 mem_ack_i = 1'b0;
            end
        end
        if (!done)
            chk("miss_timeout", 256'd0, 256'd1);
    endtask

    initial begin
        int stalls;
        logic [255:0] exp_line;

        rst_i      = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         32'h2};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0108, 32'hDEADBEEF,  32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_011C, 32'h0,         32'h8};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,         32'h4};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0107, 32'h0,         32'h2};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         32'hDEADBEEF};

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_stall",    cpu_stall_o,  0);
        chk("rst_enable",   mem_enable_o, 0);
        chk("rst_write",    mem_write_o,  0);
        chk("rst_addr",     mem_addr_o,   0);
        chk("rst_memdata",  mem_data_o,   0);
        chk("rst_cpudata",  cpu_data_o,   0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Cold miss on 0x104, ack after 5 wait cycles
        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        run_miss(5, line_of(32'h1), stalls);
        chk("t1_stall_cycles", stalls, 7);
        chk("t1_phases",       nph, 1);
        chk("t1_fill_write",   ph_wr[0], 0);
        chk("t1_fill_addr",    ph_addr[0], 32'h100);
        chk("t1_done_data",    cpu_data_o, 32'h2);
        chk("t1_done_stall",   cpu_stall_o, 0);
        chk("t1_done_enable",  mem_enable_o, 0);

        // Hit table on line 0x100
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_i);
            #1 drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk_i);
            chk($sformatf("vec%0d_stall", i),  cpu_stall_o, 0);
            chk($sformatf("vec%0d_enable", i), mem_enable_o, 0);
            if (vecs[i].rd && !vecs[i].wr || !vecs[i].rd && !vecs[i].wr)
                chk($sformatf("vec%0d_data", i), cpu_data_o, vecs[i].exp_data);
        end

        // Conflict miss on dirty line: write-back of old line then fill
        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_2108, 32'h0);
        run_miss(2, line_of(32'h11), stalls);
        exp_line = line_of(32'h1);
        exp_line[64 +: 32] = 32'hDEADBEEF;
        chk("t4_stall_cycles", stalls, 7);
        chk("t4_phases",       nph, 2);
        chk("t4_wb_write",     ph_wr[0], 1);
        chk("t4_wb_addr",      ph_addr[0], 32'h100);
        chk("t4_wb_data",      ph_data[0], exp_line);
        chk("t4_fill_write",   ph_wr[1], 0);
        chk("t4_fill_addr",    ph_addr[1], 32'h2100);
        chk("t4_done_data",    cpu_data_o, 32'h13);
        chk("t4_done_enable",  mem_enable_o, 0);

        // Reset in the middle of a fill; a stray ack afterwards is ignored
        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        @(negedge clk_i);
        chk("t5_miss_stall", cpu_stall_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("t5_fill_enable", mem_enable_o, 1);
        chk("t5_fill_addr",   mem_addr_o, 32'h100);
        #1 rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t5_rst_enable",  mem_enable_o, 0);
        chk("t5_rst_stall",   cpu_stall_o, 0);
        chk("t5_rst_addr",    mem_addr_o, 0);
        chk("t5_rst_write",   mem_write_o, 0);
        chk("t5_rst_cpudata", cpu_data_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        mem_data_i = line_of(32'h55);
        mem_ack_i  = 1'b1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("t5_ack_enable", mem_enable_o, 0);
        chk("t5_ack_stall",  cpu_stall_o, 0);

        // Tag 0x10 is still stored at index 8, so only the cleared valid bit forces this miss
        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_2108, 32'h0);
        run_miss(1, line_of(32'h21), stalls);
        chk("t5_revalid_stalls", stalls, 3);
        chk("t5_revalid_phases", nph, 1);
        chk("t5_revalid_addr",   ph_addr[0], 32'h2100);
        chk("t5_revalid_data",   cpu_data_o, 32'h23);

        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        run_miss(1, line_of(32'h1), stalls);
        chk("t5_reload_stalls", stalls, 3);
        chk("t5_reload_phases", nph, 1);
        chk("t5_reload_write",  ph_wr[0], 0);
        chk("t5_reload_addr",   ph_addr[0], 32'h100);
        chk("t5_reload_data",   cpu_data_o, 32'h2);

        // Read+write together on a clean-line miss: fill only, store merged
        @(posedge clk_i);
        #1 drive(1'b1, 1'b1, 32'h0000_2104, 32'hCAFEF00D);
        run_miss(0, line_of(32'h21), stalls);
        chk("t6_stalls",     stalls, 2);
        chk("t6_phases",     nph, 1);
        chk("t6_fill_write", ph_wr[0], 0);
        chk("t6_fill_addr",  ph_addr[0], 32'h2100);
        chk("t6_done_stall", cpu_stall_o, 0);

        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_2104, 32'h0);
        @(negedge clk_i);
        chk("t6_hit_data",  cpu_data_o, 32'hCAFEF00D);
        chk("t6_hit_stall", cpu_stall_o, 0);

        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        run_miss(1, line_of(32'h1), stalls);
        exp_line = line_of(32'h21);
        exp_line[32 +: 32] = 32'hCAFEF00D;
        chk("t6_evict_stalls",  stalls, 5);
        chk("t6_evict_phases",  nph, 2);
        chk("t6_evict_wb",      ph_wr[0], 1);
        chk("t6_evict_wb_addr", ph_addr[0], 32'h2100);
        chk("t6_evict_wb_data", ph_data[0], exp_line);
        chk("t6_evict_fill",    ph_addr[1], 32'h100);
        chk("t6_evict_data",    cpu_data_o, 32'h2);

        @(posedge clk_i);
        #1 drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        chk("end_idle_data", cpu_data_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage (load/store address, store data, MemRead/MemWrite) and a slow off-chip data memory with a 256-bit line interface.
- Holds tag, valid, dirty and data arrays internally.
- Returns hit data combinationally.
- Stalls the whole pipeline through cpu_stall_o while a miss is serviced by an FSM.

Parameters:
LINES, 16, number of cache lines (power of two)
LINE_BITS, 256, line width in bits (32 bytes, 8 words)
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cpu_addr_i  in  32  byte address from MEM stage (ALU result)
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  pipeline stall
mem_addr_o  out  32  line-aligned memory address
mem_data_o  out  256  write-back line data
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1 = write-back, 0 = line fill
mem_data_i  in  256  fill line data
mem_ack_i  in  1  one-cycle completion pulse

Interface decision:
- One clock.
- Reset is asynchronous and active-low.

Behaviour:

Address split:
- offset = addr[4:0].
- word select = addr[4:2].
- index = addr[8:5].
- tag = addr[31:9] (23 bits).
- Byte bits [1:0] are ignored; accesses are word-aligned.

Request and hit rules:
- req = MemRead | MemWrite. If both are high, the access is treated as a store.
- hit = valid[index] & (tag_array[index] == tag).

Reset (rst_i low, asynchronous):
- State = IDLE; all valid and dirty bits = 0.
- cpu_stall_o, mem_enable_o and mem_write_o = 0.
- mem_addr_o, mem_data_o and cpu_data_o = 0.
- Data and tag arrays are not cleared.
- Reset mid-miss aborts the transaction. mem_enable_o drops immediately; any later mem_ack_i is ignored.

Outputs in IDLE:
- cpu_stall_o = req & ~hit, combinational in the request cycle.
- Load hit: cpu_data_o = selected word in the same cycle, no stall.
- Store hit: the word is written at the clock edge and dirty[index] is set.
- No request: cpu_data_o holds 0, no state change.

FSM states and transitions:
- IDLE: req & ~hit & valid & dirty -> WB_REQ. req & ~hit otherwise -> FILL_REQ.
- WB_REQ:
  - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={old_tag,index,5'b0}, mem_data_o=line.
  - Holds all of these until mem_ack_i, then -> FILL_REQ.
- FILL_REQ:
  - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={tag,index,5'b0}.
  - On mem_ack_i: captures mem_data_i into the line, sets tag, valid=1, dirty=0, then -> FILL_DONE.
- FILL_DONE:
  - mem_enable_o=0; the access is now a hit.
  - A load presents its data here. A store merges its word and sets dirty.
  - cpu_stall_o=0 in this cycle -> IDLE.

Stall and handshake rules:
- cpu_stall_o = 1 in WB_REQ and FILL_REQ, including the cycle in which the ack arrives.
- mem_enable_o deasserts in the cycle after the ack cycle.
- Back-to-back requests must never start a new memory request in FILL_DONE.
- Memory latency is unbounded; the FSM waits indefinitely.
- A mem_ack_i arriving in IDLE or FILL_DONE is ignored.
- CPU inputs are held stable by the stalled pipeline. The block samples the address at miss detection and uses the registered copy through the miss.

Test Plan:
1. Reset, load 0x0000_0104 with memory line 0x100 = words 0..7 {1..8}, ack after 5 cycles -> stall for 7 cycles (IDLE, 5 wait cycles, ack cycle), mem_addr_o=0x100 with mem_write_o=0, then cpu_data_o=2 in FILL_DONE, no stall.
2. Immediately reload 0x104 -> hit: cpu_data_o=2 same cycle, cpu_stall_o=0, mem_enable_o stays 0.
3. Store 0xDEADBEEF to 0x108 (hit), then load 0x108 -> 0xDEADBEEF; dirty[8]=1; no memory traffic.
4. Load 0x2108 (same index 8, different tag) -> WB_REQ with mem_addr_o=0x100, mem_write_o=1, mem_data_o word2=0xDEADBEEF. Then FILL_REQ with mem_addr_o=0x2100; the filled word is returned.
5. Assert rst_i low during FILL_REQ, then release and pulse mem_ack_i -> outputs 0 and IDLE; the ack is ignored; a subsequent load of 0x104 misses (valid was cleared).
6. MemRead and MemWrite both high on a miss to a clean line -> fill only (no write-back); the stored word is merged and the line is dirty afterwards.
